mem_line_xfer_ctrl: RTL and testbench
=====================================

// Module: mem_line_xfer_ctrl
// PURPOSE
//  Line-transfer controller between the MESI cache controller and main_memory.
//  - Converts one 4-word (16-byte) cache-line fill or write-back into a 4-beat memory burst.
//  - Issues the memory request, sequences beats on memory ready pulses, assembles/serialises the line.
//  - Returns a single done pulse to the cache; a watchdog flags a stalled memory.
// PARAMETERS
//  ADDR_W          32   byte-address width
//  WORD_W          32   memory beat width
//  LINE_WORDS      4    beats per line; fixed at 4, other values unsupported
//  TIMEOUT_CYCLES  64   max cycles waiting for any single beat before error
// PORTS
//  clk           in   1        single clock, rising edge
//  reset         in   1        synchronous, active-high
//  line_req      in   1        cache requests a line transfer; sampled only when line_busy=0
//  line_rw       in   1        1 = write-back, 0 = fill
//  line_addr     in   ADDR_W   line address; bits [3:0] ignored (forced 0)
//  line_wdata    in   128      write-back data, word0 = [31:0]
//  line_busy     out  1        transfer in progress
//  line_done     out  1        one-cycle pulse, transfer finished (ok or error)
//  line_err      out  1        one-cycle pulse with line_done on timeout
//  line_rdata    out  128      fill data, valid while line_done=1, held until next fill completes
//  mem_request   out  1        one-cycle pulse starting a burst
//  mem_address   out  ADDR_W   burst base address, stable while line_busy
//  mem_rw        out  1        1 = write, 0 = read, stable while line_busy
//  mem_data_in   out  WORD_W   current write beat word
//  mem_ready     in   1        per-beat pulse from memory (read data valid / write word consumed)
//  mem_data_out  in   WORD_W   read beat word, valid when mem_ready=1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, beat counter 0, watchdog 0, line buffer 0.
//  States: IDLE -> ISSUE -> BEAT -> DONE -> IDLE; BEAT -> ERR -> IDLE.
//  - IDLE: when line_req=1, capture {line_addr[31:4],4'b0}, line_rw and line_wdata.
//    Go to ISSUE; line_busy=1 from the next cycle.
//  - ISSUE: mem_request=1 for exactly this cycle; mem_data_in=word0 for writes; beat=0; watchdog=0.
//    Go to BEAT.
//  - BEAT, read: on mem_ready, buffer[beat] <= mem_data_out.
//  - BEAT, write: on mem_ready, mem_data_in advances to word[beat+1] next cycle.
//  - BEAT, both: on mem_ready, beat++ and watchdog cleared.
//    mem_ready while beat==3 -> DONE.
//    No mem_ready -> watchdog++; watchdog == TIMEOUT_CYCLES-1 -> ERR.
//  - DONE: line_done=1, line_rdata=buffer (fills only; unchanged on write-back); line_busy=0; go to IDLE.
//  - ERR: line_done=1, line_err=1, line_busy=0; line_rdata not updated; go to IDLE.
//  Latency: fill done = ISSUE + N memory cycles + 1. Minimum req -> done is 6 cycles when mem_ready arrives every cycle.
//  Boundaries:
//  - line_req while line_busy, or in the DONE/ERR cycle: ignored, not queued; requester re-asserts.
//  - mem_ready in IDLE, ISSUE, DONE or ERR: ignored (stray beat never shifts the buffer).
//  - Beat counter is 2 bits: wraps only via DONE; never exceeds 3.
//  - Watchdog saturates; TIMEOUT_CYCLES=1 means error unless ready arrives in the first BEAT cycle.
//  - Reset mid-transfer: returns to IDLE next edge; no line_done; mem_request deasserted; partial buffer discarded.
//  - Address increment per beat is memory's job; mem_address stays at the line base.
// STRUCTURE
//  Shared package mem_xfer_pkg:
//  - xfer_state_t enum {IDLE, ISSUE, BEAT, DONE, ERR} (3 bits)
//  - LINE_WORDS=4, LINE_BYTES=16, OP_READ=1'b0, OP_WRITE=1'b1 constants
//  - line_t typedef (128-bit)
//  Single module; the watchdog may be split into sub-module xfer_watchdog (clear/inc/expire) for reuse.
// TESTING
//  1. Fill 0x0000_1234, memory returns 0xA0,0xA1,0xA2,0xA3 one per cycle.
//     -> one mem_request, mem_address=0x0000_1230, line_rdata=0x000000A3_000000A2_000000A1_000000A0.
//     -> done 6 cycles after req, line_err=0.
//  2. Write-back 0x100, wdata words W0..W3, mem_ready every 3rd cycle.
//     -> mem_rw=1; mem_data_in=W0,W1,W2,W3 in order; each changes only after a ready; single done.
//  3. Fill with memory stalling after beat 1, TIMEOUT_CYCLES=8.
//     -> line_err=line_done=1 exactly 8 cycles after last ready; line_rdata unchanged from previous fill.
//  4. line_req held high across a transfer and in the DONE cycle.
//     -> exactly one transfer per IDLE acceptance; second starts the cycle after DONE.
//     -> stray mem_ready in IDLE leaves the buffer unchanged.
//  5. Assert reset during beat 2 of a fill.
//     -> next cycle all outputs 0, state IDLE, no line_done; subsequent fill completes normally.

Source files
------------

// File: rtl/mem_xfer_pkg.sv
// rtl/mem_xfer_pkg.sv - shared types and constants for the cache line transfer controller
package mem_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    BEAT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } xfer_state_t;

  localparam int   LINE_WORDS = 4;
  localparam int   LINE_BYTES = 16;
  localparam logic OP_READ    = 1'b0;
  localparam logic OP_WRITE   = 1'b1;

  typedef logic [LINE_BYTES*8-1:0] line_t;

  // Bit offset of beat word idx inside a line.
  function automatic int word_lsb(input logic [1:0] idx, input int word_w);
    return int'(idx) * word_w;
  endfunction

endpackage

// File: rtl/mem_line_xfer_ctrl_if.sv
// rtl/mem_line_xfer_ctrl_if.sv - cache-side and memory-side signals of the line transfer controller
interface mem_line_xfer_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  import mem_xfer_pkg::line_t;

  logic              line_req;
  logic              line_rw;
  logic [ADDR_W-1:0] line_addr;
  line_t             line_wdata;
  logic              line_busy;
  logic              line_done;
  logic              line_err;
  line_t             line_rdata;

  logic              mem_request;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_rw;
  logic [WORD_W-1:0] mem_data_in;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_data_out;

  // Controller view.
  modport slave (
    input  line_req, line_rw, line_addr, line_wdata, mem_ready, mem_data_out,
    output line_busy, line_done, line_err, line_rdata,
           mem_request, mem_address, mem_rw, mem_data_in
  );

  // Environment view: cache requester plus main memory.
  modport master (
    output line_req, line_rw, line_addr, line_wdata, mem_ready, mem_data_out,
    input  line_busy, line_done, line_err, line_rdata,
           mem_request, mem_address, mem_rw, mem_data_in
  );

endinterface

// File: rtl/xfer_watchdog.sv
// rtl/xfer_watchdog.sv - saturating stall counter, expires at TIMEOUT_CYCLES-1 idle beats
module xfer_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != LIMIT)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expire_o = (count_q == LIMIT);

endmodule

// File: rtl/mem_line_xfer_ctrl.sv
// rtl/mem_line_xfer_ctrl.sv - turns one cache line fill/write-back into a 4-beat memory burst
module mem_line_xfer_ctrl
  import mem_xfer_pkg::xfer_state_t, mem_xfer_pkg::IDLE, mem_xfer_pkg::ISSUE,
         mem_xfer_pkg::BEAT, mem_xfer_pkg::DONE, mem_xfer_pkg::ERR,
         mem_xfer_pkg::line_t, mem_xfer_pkg::OP_WRITE, mem_xfer_pkg::word_lsb;
#(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int LINE_WORDS     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           reset,
  mem_line_xfer_ctrl_if.slave bus
);

  localparam logic [1:0] LAST_BEAT = 2'(LINE_WORDS - 1);

  xfer_state_t       state_q;
  logic [1:0]        beat_q;
  logic [1:0]        beat_nxt;
  line_t             buf_q;
  line_t             fill_line;
  line_t             line_rdata_q;
  logic              line_busy_q;
  logic              line_done_q;
  logic              line_err_q;
  logic              mem_request_q;
  logic              mem_rw_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [WORD_W-1:0] mem_data_in_q;
  logic              wd_clear;
  logic              wd_inc;
  logic              wd_expire;
  logic              unused_addr_lsb;

  assign beat_nxt        = beat_q + 2'd1;
  assign unused_addr_lsb = ^bus.line_addr[3:0];

  // Buffer with the arriving read beat merged in, so the last beat lands in line_rdata directly.
  always_comb begin
    fill_line = buf_q;
    fill_line[word_lsb(beat_q, WORD_W) +: WORD_W] = bus.mem_data_out;
  end

  assign wd_clear = (state_q == ISSUE) || ((state_q == BEAT) && bus.mem_ready);
  assign wd_inc   = (state_q == BEAT) && !bus.mem_ready;

  xfer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear_i (wd_clear),
    .inc_i   (wd_inc),
    .expire_o(wd_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      beat_q        <= 2'd0;
      buf_q         <= '0;
      line_rdata_q  <= '0;
      line_busy_q   <= 1'b0;
      line_done_q   <= 1'b0;
      line_err_q    <= 1'b0;
      mem_request_q <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      line_done_q   <= 1'b0;
      line_err_q    <= 1'b0;
      mem_request_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.line_req) begin
            mem_address_q <= {bus.line_addr[ADDR_W-1:4], 4'b0000};
            mem_rw_q      <= bus.line_rw;
            buf_q         <= bus.line_wdata;
            mem_data_in_q <= (bus.line_rw == OP_WRITE) ? bus.line_wdata[WORD_W-1:0] : '0;
            line_busy_q   <= 1'b1;
            mem_request_q <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          beat_q  <= 2'd0;
          state_q <= BEAT;
        end
        BEAT: begin
          if (bus.mem_ready) begin
            beat_q <= beat_nxt;
            if (mem_rw_q == OP_WRITE) begin
              if (beat_q != LAST_BEAT) begin
                mem_data_in_q <= buf_q[word_lsb(beat_nxt, WORD_W) +: WORD_W];
              end
            end else begin
              buf_q <= fill_line;
            end
            if (beat_q == LAST_BEAT) begin
              line_busy_q <= 1'b0;
              line_done_q <= 1'b1;
              if (mem_rw_q != OP_WRITE) begin
                line_rdata_q <= fill_line;
              end
              state_q <= DONE;
            end
          end else if (wd_expire) begin
            line_busy_q <= 1'b0;
            line_done_q <= 1'b1;
            line_err_q  <= 1'b1;
            state_q     <= ERR;
          end
        end
        DONE, ERR: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign bus.line_busy   = line_busy_q;
  assign bus.line_done   = line_done_q;
  assign bus.line_err    = line_err_q;
  assign bus.line_rdata  = line_rdata_q;
  assign bus.mem_request = mem_request_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_rw      = mem_rw_q;
  assign bus.mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mem_line_xfer_ctrl.sv
// tb/tb_mem_line_xfer_ctrl.sv - scoreboard bench for mem_line_xfer_ctrl with a memory responder
module tb_mem_line_xfer_ctrl;
  import mem_xfer_pkg::line_t;

  localparam int T = 8;

  typedef struct packed {
    logic            rw;
    logic [31:0]     addr;
    line_t           wdata;
    line_t           rwords;
    logic [3:0][7:0] gaps;
  } txn_t;

  typedef struct packed {
    logic        err;
    line_t       rdata;
    logic [31:0] done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_line_xfer_ctrl_if #(.ADDR_W(32), .WORD_W(32)) bus ();

  mem_line_xfer_ctrl #(
    .ADDR_W(32), .WORD_W(32), .LINE_WORDS(4), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    rst_epoch = 0;
  int    accepts = 0;
  int    reqs_seen = 0;
  line_t model_fill = '0;
  exp_t  exp_q[$];
  txn_t  mem_q[$];

  always @(posedge clk) begin
    cyc++;
    if (reset) rst_epoch++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input line_t l, input int b);
    return l[b*32 +: 32];
  endfunction

  // Reference model: outcome and completion cycle from the gap schedule alone.
  task automatic push_txn(input txn_t t, input int acc, output int done_at);
    exp_t e;
    int   s = acc + 2;
    logic err = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (!err) begin
        if (int'(t.gaps[b]) >= T) begin
          err = 1'b1;
          s += T;
        end else begin
          s += int'(t.gaps[b]) + 1;
        end
      end
    end
    e.err      = err;
    e.done_cyc = s;
    if (!t.rw && !err) model_fill = t.rwords;
    e.rdata = model_fill;
    exp_q.push_back(e);
    mem_q.push_back(t);
    accepts++;
    done_at = s;
  endtask

  task automatic drive_fields(input txn_t t);
    bus.line_rw    = t.rw;
    bus.line_addr  = t.addr;
    bus.line_wdata = t.wdata;
  endtask

  task automatic scramble_fields();
    bus.line_rw    = 1'($urandom_range(0, 1));
    bus.line_addr  = $urandom;
    bus.line_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.line_busy || bus.line_done || reset) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timed out actual=busy expected=idle");
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL wait_done timed out actual=pending expected=done");
    end
  endtask

  task automatic run_xfer(input txn_t t, output int acc);
    int d;
    wait_idle();
    acc = cyc;
    push_txn(t, acc, d);
    drive_fields(t);
    bus.line_req = 1'b1;
    @(negedge clk);
    bus.line_req = 1'b0;
    scramble_fields();
  endtask

  function automatic txn_t make_txn(input logic rw, input logic [31:0] addr,
                                    input logic [3:0][7:0] gaps);
    txn_t t;
    t.rw     = rw;
    t.addr   = addr;
    t.wdata  = {$urandom, $urandom, $urandom, $urandom};
    t.rwords = {$urandom, $urandom, $urandom, $urandom};
    t.gaps   = gaps;
    return t;
  endfunction

  // Memory responder: serves beats per the transaction's gap schedule, random stray ready when idle.
  task automatic serve(input txn_t t);
    int e0 = rst_epoch;
    int g;
    check("issue_addr", bus.mem_address, {t.addr[31:4], 4'h0});
    check("issue_rw", bus.mem_rw, t.rw);
    check("issue_busy", bus.line_busy, 1'b1);
    if (t.rw) check("issue_wdata", bus.mem_data_in, word_of(t.wdata, 0));
    bus.mem_ready    = 1'($urandom_range(0, 1));
    bus.mem_data_out = $urandom;
    for (int b = 0; b < 4; b++) begin
      g = int'(t.gaps[b]);
      for (int i = 0; i < ((g >= T) ? T : g); i++) begin
        @(negedge clk);
        bus.mem_ready = 1'b0;
        if (rst_epoch != e0) return;
        if (t.rw) check("wr_hold", bus.mem_data_in, word_of(t.wdata, b));
      end
      if (g >= T) return;
      @(negedge clk);
      if (rst_epoch != e0) begin
        bus.mem_ready = 1'b0;
        return;
      end
      bus.mem_ready    = 1'b1;
      bus.mem_data_out = t.rw ? $urandom : word_of(t.rwords, b);
      if (t.rw) check("wr_beat", bus.mem_data_in, word_of(t.wdata, b));
    end
  endtask

  initial begin
    txn_t t;
    bus.mem_ready    = 1'b0;
    bus.mem_data_out = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_request) begin
        reqs_seen++;
        if (mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_request actual=1 expected=0 cycle=%0d", cyc);
        end else begin
          t = mem_q.pop_front();
          serve(t);
        end
      end else begin
        bus.mem_ready    = 1'($urandom_range(0, 1));
        bus.mem_data_out = $urandom;
      end
    end
  end

  // Monitor: pops one expectation per line_done.
  initial begin
    exp_t  e;
    line_t held = '0;
    int    my_epoch = 0;
    forever begin
      @(negedge clk);
      if (rst_epoch != my_epoch) begin
        my_epoch = rst_epoch;
        exp_q.delete();
        held = '0;
      end
      if (bus.line_err && !bus.line_done) check("err_without_done", 1'b1, 1'b0);
      if (bus.line_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", bus.line_done, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("done_err", bus.line_err, e.err);
          check("done_rdata", bus.line_rdata, e.rdata);
          check("done_cycle", cyc, e.done_cyc);
          check("done_busy", bus.line_busy, 1'b0);
          held = e.rdata;
        end
      end else if (!bus.line_busy) begin
        check("rdata_held", bus.line_rdata, held);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    txn_t t, ta, tb;
    int   acc, da, db;
    reset         = 1'b1;
    bus.line_req  = 1'b0;
    bus.line_rw   = 1'b0;
    bus.line_addr = '0;
    bus.line_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.line_busy, 1'b0);
    check("rst_done", bus.line_done, 1'b0);
    check("rst_err", bus.line_err, 1'b0);
    check("rst_rdata", bus.line_rdata, '0);
    check("rst_req", bus.mem_request, 1'b0);
    check("rst_addr", bus.mem_address, '0);
    check("rst_rw", bus.mem_rw, 1'b0);
    check("rst_wdata", bus.mem_data_in, '0);
    reset = 1'b0;
    @(negedge clk);

    // Fill with back-to-back beats.
    t = make_txn(1'b0, 32'h0000_1234, {8'd0, 8'd0, 8'd0, 8'd0});
    t.rwords = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    run_xfer(t, acc);
    wait_done();

    // Write-back, memory ready every third cycle.
    t = make_txn(1'b1, 32'h0000_0100, {8'd2, 8'd2, 8'd2, 8'd2});
    run_xfer(t, acc);
    wait_done();

    // Fill stalling after beat 1.
    t = make_txn(1'b0, $urandom, {8'd0, 8'(T), 8'd0, 8'd0});
    run_xfer(t, acc);
    wait_done();

    // Watchdog edges: last legal wait, then first illegal wait.
    t = make_txn(1'b0, $urandom, {8'd0, 8'd0, 8'd0, 8'(T - 1)});
    run_xfer(t, acc);
    wait_done();
    t = make_txn(1'b1, $urandom, {8'd0, 8'd0, 8'd0, 8'(T)});
    run_xfer(t, acc);
    wait_done();

    // line_req held across a transfer and its DONE cycle.
    ta = make_txn(1'b0, $urandom, {8'd1, 8'd0, 8'd2, 8'd0});
    tb = make_txn(1'b0, $urandom, {8'd0, 8'd1, 8'd0, 8'd0});
    wait_idle();
    acc = cyc;
    push_txn(ta, acc, da);
    push_txn(tb, da + 1, db);
    drive_fields(ta);
    bus.line_req = 1'b1;
    @(negedge clk);
    drive_fields(tb);
    for (int n = 0; n < 100 && cyc < da + 1; n++) @(negedge clk);
    @(negedge clk);
    bus.line_req = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);

    // Reset during beat 2 of a fill.
    t = make_txn(1'b0, $urandom, {8'd0, 8'd0, 8'd0, 8'd0});
    run_xfer(t, acc);
    for (int n = 0; n < 20 && cyc < acc + 4; n++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", bus.line_busy, 1'b0);
    check("mid_rst_done", bus.line_done, 1'b0);
    check("mid_rst_req", bus.mem_request, 1'b0);
    check("mid_rst_rdata", bus.line_rdata, '0);
    check("mid_rst_addr", bus.mem_address, '0);
    check("mid_rst_wdata", bus.mem_data_in, '0);
    model_fill = '0;
    mem_q.delete();
    t = make_txn(1'b0, $urandom, {8'd0, 8'd1, 8'd0, 8'd2});
    run_xfer(t, acc);
    wait_done();

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      logic [3:0][7:0] gaps;
      for (int b = 0; b < 4; b++) begin
        int r = $urandom_range(0, 39);
        gaps[b] = (r < 34) ? 8'(r % 3) : ((r < 37) ? 8'(T - 1) : 8'(T));
      end
      t = make_txn(1'($urandom_range(0, 1)), $urandom, gaps);
      run_xfer(t, acc);
      if ($urandom_range(0, 1) == 1) wait_done();
    end
    wait_done();
    repeat (4) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    check("request_count", reqs_seen, accepts);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
